// File: rtl/binary_counter_updown_load.sv
// Modulo-MODULUS up/down counter with synchronous clear, clamped parallel load and cascadable terminal count.
// Define BINARY_COUNTER_SAT_EN to hold at the end of range instead of wrapping.
module binary_counter_updown_load #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 256
) (
    input  logic             CLK,
    input  logic             Clear_b,
    input  logic             Sync_clr,
    input  logic             Load,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             Count,
    input  logic             Up,
    output logic [WIDTH-1:0] A_count,
    output logic             C_out,
    output logic             Wrap_flag
);

    if (WIDTH < 2 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_param
        $error("binary_counter_updown_load: illegal WIDTH/MODULUS combination");
    end

`ifdef BINARY_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO    = '0;

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             at_term;

    // Terminal value depends on direction: top of range going up, zero going down.
    always_comb begin
        at_term = Up ? (count_q == MAX_VAL) : (count_q == ZERO);
        C_out   = Count & ~Load & ~Sync_clr & Clear_b & at_term;
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = C_out;
        if (Sync_clr) begin
            count_d = ZERO;
        end else if (Load) begin
            count_d = (Data_in > MAX_VAL) ? MAX_VAL : Data_in;
        end else if (Count) begin
            if (Up) begin
                if (count_q == MAX_VAL) count_d = SAT ? MAX_VAL : ZERO;
                else                    count_d = count_q + 1'b1;
            end else begin
                if (count_q == ZERO)    count_d = SAT ? ZERO : MAX_VAL;
                else                    count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge Clear_b) begin
        if (!Clear_b) begin
            count_q <= ZERO;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign A_count   = count_q;
    assign Wrap_flag = wrap_q;

endmodule

// File: tb/tb_binary_counter_updown_load.sv
// Directed bench for binary_counter_updown_load at WIDTH=4, MODULUS=10, plus a two-stage cascade.
module tb_binary_counter_updown_load;

    localparam int W = 4;
    localparam int M = 10;
`ifdef BINARY_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         Clear_b, Sync_clr, Load, Count, Up;
    logic [W-1:0] Data_in;
    logic [W-1:0] A_count;
    logic         C_out, Wrap_flag;

    logic         cas_clr, cas_en;
    logic [W-1:0] lo_a, hi_a;
    logic         lo_c, hi_c, lo_w, hi_w;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] a, prev;

    always #5 CLK = ~CLK;

    binary_counter_updown_load #(.WIDTH(W), .MODULUS(M)) u_dut (
        .CLK(CLK), .Clear_b(Clear_b), .Sync_clr(Sync_clr), .Load(Load), .Data_in(Data_in),
        .Count(Count), .Up(Up), .A_count(A_count), .C_out(C_out), .Wrap_flag(Wrap_flag)
    );

    binary_counter_updown_load #(.WIDTH(W), .MODULUS(M)) u_lo (
        .CLK(CLK), .Clear_b(Clear_b), .Sync_clr(cas_clr), .Load(1'b0), .Data_in('0),
        .Count(cas_en), .Up(1'b1), .A_count(lo_a), .C_out(lo_c), .Wrap_flag(lo_w)
    );

    binary_counter_updown_load #(.WIDTH(W), .MODULUS(M)) u_hi (
        .CLK(CLK), .Clear_b(Clear_b), .Sync_clr(cas_clr), .Load(1'b0), .Data_in('0),
        .Count(lo_c), .Up(1'b1), .A_count(hi_a), .C_out(hi_c), .Wrap_flag(hi_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [W-1:0] exp_inc(input logic [W-1:0] v);
        if (v == W'(M - 1)) return SAT ? v : '0;
        return v + 1'b1;
    endfunction

    function automatic logic [W-1:0] exp_dec(input logic [W-1:0] v);
        if (v == '0) return SAT ? v : W'(M - 1);
        return v - 1'b1;
    endfunction

    initial begin
        Clear_b = 1'b0; Sync_clr = 1'b0; Load = 1'b0; Count = 1'b0; Up = 1'b1; Data_in = '0;
        cas_clr = 1'b0; cas_en = 1'b0;

        // reset values
        #3;
        check("rst_a", 32'(A_count), 32'd0);
        check("rst_wrap", 32'(Wrap_flag), 32'd0);
        check("rst_c", 32'(C_out), 32'd0);

        @(negedge CLK);
        Clear_b = 1'b1; Load = 1'b1; Data_in = 4'd7;
        tick();
        check("load7_a", 32'(A_count), 32'd7);
        check("load7_wrap", 32'(Wrap_flag), 32'd0);

        // count to terminal, then async reset mid-cycle with Wrap_flag high
        Load = 1'b0; Count = 1'b1; Up = 1'b1;
        tick();
        check("up8_a", 32'(A_count), 32'd8);
        tick();
        check("up9_a", 32'(A_count), 32'd9);
        check("up9_c", 32'(C_out), 32'd1);
        tick();
        check("wrap_a", 32'(A_count), 32'(exp_inc(4'd9)));
        check("wrap_flag", 32'(Wrap_flag), 32'd1);
        #2;
        Clear_b = 1'b0;
        #1;
        check("async_a", 32'(A_count), 32'd0);
        check("async_wrap", 32'(Wrap_flag), 32'd0);
        check("async_c", 32'(C_out), 32'd0);
        @(negedge CLK);
        Clear_b = 1'b1;

        // up-count sweep from 0 over ten edges
        a = '0;
        #1;
        check("sweep_c0", 32'(C_out), 32'd0);
        for (int i = 0; i < 10; i++) begin
            prev = a;
            a = exp_inc(a);
            exp_q.push_back(a);
            tick();
            check("sweep_a", 32'(A_count), 32'(exp_q.pop_front()));
            check("sweep_wrap", 32'(Wrap_flag), 32'(prev == 4'd9));
            check("sweep_c", 32'(C_out), 32'(a == 4'd9));
        end

        // down-count through zero, then reverse direction
        Count = 1'b0; Load = 1'b1; Data_in = 4'd2;
        tick();
        check("load2_a", 32'(A_count), 32'd2);
        Load = 1'b0; Count = 1'b1; Up = 1'b0;
        tick();
        check("dn1_a", 32'(A_count), 32'd1);
        check("dn1_c", 32'(C_out), 32'd0);
        tick();
        check("dn0_a", 32'(A_count), 32'd0);
        check("dn0_c", 32'(C_out), 32'd1);
        tick();
        a = exp_dec(4'd0);
        check("dnwrap_a", 32'(A_count), 32'(a));
        check("dnwrap_flag", 32'(Wrap_flag), 32'd1);
        Up = 1'b1;
        #1;
        check("dir_c", 32'(C_out), 32'(a == 4'd9));
        prev = a;
        a = exp_inc(a);
        tick();
        check("dir_a", 32'(A_count), 32'(a));
        check("dir_wrap", 32'(Wrap_flag), 32'(prev == 4'd9));

        // load clamp and priority
        Load = 1'b1; Data_in = 4'd13; Count = 1'b1; Up = 1'b1;
        tick();
        check("clamp_a", 32'(A_count), 32'd9);
        Data_in = 4'd3;
        #1;
        check("ldcnt_c", 32'(C_out), 32'd0);
        tick();
        check("ldcnt_a", 32'(A_count), 32'd3);
        check("ldcnt_wrap", 32'(Wrap_flag), 32'd0);
        Data_in = 4'd9;
        tick();
        Sync_clr = 1'b1; Data_in = 4'd5;
        #1;
        check("sclr_c", 32'(C_out), 32'd0);
        tick();
        check("sclr_a", 32'(A_count), 32'd0);
        check("sclr_wrap", 32'(Wrap_flag), 32'd0);
        Sync_clr = 1'b0; Data_in = 4'd6;
        tick();
        Load = 1'b0; Count = 1'b0;
        tick();
        check("hold_a", 32'(A_count), 32'd6);
        check("hold_c", 32'(C_out), 32'd0);

`ifdef BINARY_COUNTER_SAT_EN
        Load = 1'b1; Data_in = 4'd8;
        tick();
        Load = 1'b0; Count = 1'b1; Up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_up_a", 32'(A_count), 32'd9);
            check("sat_up_c", 32'(C_out), 32'd1);
        end
        Count = 1'b0; Load = 1'b1; Data_in = 4'd1;
        tick();
        Load = 1'b0; Count = 1'b1; Up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_dn_a", 32'(A_count), 32'd0);
            check("sat_dn_c", 32'(C_out), 32'd1);
        end
        Count = 1'b0;
`else
        // two-digit cascade: 25 enabled edges from 00
        cas_clr = 1'b1;
        tick();
        cas_clr = 1'b0; cas_en = 1'b1;
        for (int i = 1; i <= 25; i++) exp_q.push_back(W'(i % 10));
        for (int i = 1; i <= 25; i++) begin
            tick();
            check("cas_lo", 32'(lo_a), 32'(exp_q.pop_front()));
            if (i == 10) check("cas_hi10", 32'(hi_a), 32'd1);
        end
        cas_en = 1'b0;
        check("cas_hi25", 32'(hi_a), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/binary_counter_updown_load.md
# binary_counter_updown_load

Parametrised modulo-N up/down binary counter with synchronous parallel load, synchronous clear and a cascadable terminal-count output. Next generation of the team's 4-bit loadable counter: arbitrary width and modulus, direction control, and a registered wrap flag for downstream sequencing logic. Used as a general event/timebase counter and, cascaded via `C_out` to the next stage's `Count`, as a multi-digit counter.

## Interface
- `WIDTH`, 8: counter width in bits; ≥ 2.
- `MODULUS`, 256: count range is 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2^WIDTH; elaboration fails outside it.
- `CLK`  in  1  single clock; all state changes on its rising edge.
- `Clear_b`  in  1  asynchronous, active-low reset.
- `Sync_clr`  in  1  synchronous clear, active high.
- `Load`  in  1  synchronous parallel load, active high.
- `Data_in`  in  WIDTH  value to load.
- `Count`  in  1  count enable, active high.
- `Up`  in  1  direction: 1 = increment, 0 = decrement.
- `A_count`  out  WIDTH  registered count value.
- `C_out`  out  1  combinational terminal-count / carry-borrow output.
- `Wrap_flag`  out  1  registered; one-cycle pulse after a terminal event.

## Operation
- **Priority at each rising `CLK` edge:** `Clear_b` low, then `Sync_clr`, then `Load`, then `Count`, then hold.
- **Asynchronous reset.** While `Clear_b` = 0: `A_count` = 0 and `Wrap_flag` = 0 immediately, independent of `CLK`. The counter resumes at the first rising edge after `Clear_b` returns high.
- **`Sync_clr` = 1:** `A_count` ← 0 and `Wrap_flag` ← 0, regardless of `Load` and `Count`.
- **`Load` = 1:**
  - If `Data_in` ≤ MODULUS-1: `A_count` ← `Data_in`.
  - Otherwise `A_count` ← MODULUS-1 (clamp).
  - `Count` and `Up` are ignored.
- **Counting (`Count` = 1, `Up` = 1):**
  - `A_count` ← `A_count` + 1.
  - At MODULUS-1 it wraps to 0.
- **Counting (`Count` = 1, `Up` = 0):**
  - `A_count` ← `A_count` - 1.
  - At 0 it wraps to MODULUS-1.
- **Arithmetic.** All arithmetic is WIDTH bits. The wrap comparison uses the MODULUS-1 constant, not the natural WIDTH-bit rollover; the two coincide only when MODULUS = 2^WIDTH.
- **`C_out`.** `C_out` = `Count` & ~`Load` & ~`Sync_clr` & `Clear_b` & T, where T is:
  - (`A_count` == MODULUS-1) when `Up` = 1;
  - (`A_count` == 0) when `Up` = 0.
- **`Wrap_flag`.** `Wrap_flag` ← `C_out` on every edge; it is the registered copy of the terminal event.
- **Direction change.** `Up` may change on any cycle. The new direction applies at the next edge, with no extra latency.

## Timing
- `Load`, `Sync_clr` and count results are visible on `A_count` one cycle after the sampling edge.
- `C_out` is combinational from `A_count` and the control inputs. It is valid in the same cycle as the terminal condition and is intended to feed the next stage's `Count` for ripple-free synchronous cascading.
- `Wrap_flag` rises one cycle after the edge at which `C_out` was sampled high and stays high for exactly one cycle unless `C_out` is high again.
- **Reset values:** `A_count` = 0, `Wrap_flag` = 0, `C_out` = 0.
- **Reset mid-operation.** Asserting `Clear_b` mid-count or during a load takes effect immediately; the pending load or increment is lost.

## Configuration
- **Macro:** `BINARY_COUNTER_SAT_EN`.
- **Defined:** saturating mode.
  - Counting up at MODULUS-1 holds MODULUS-1.
  - Counting down at 0 holds 0.
  - `C_out` and `Wrap_flag` behave as specified and flag the attempted overrun.
- **Undefined (default):** wrap-around behaviour as specified in Operation.

## Test plan
All scenarios use WIDTH = 4, MODULUS = 10 unless stated.
- **Async reset:** drive `Clear_b` = 0 between clock edges → `A_count` = 0 and `Wrap_flag` = 0 without waiting for `CLK`. Release, then `Load` `Data_in` = 7 → `A_count` = 7 one cycle later.
- **Up-count wrap:** from 0 with `Count` = 1, `Up` = 1 for 10 cycles → 1..9, 0. `C_out` = 1 only while `A_count` = 9. `Wrap_flag` pulses in the cycle where `A_count` = 0.
- **Down-count wrap and direction change:** load 2, `Up` = 0 → 1, 0, 9. `C_out` is high while `A_count` = 0. Switch to `Up` = 1 at 9 → 0 on the next edge with `C_out` = 1.
- **Priority and clamp:**
  - `Load` = 1 with `Data_in` = 13 → `A_count` = 9.
  - `Load` = 1 with `Count` = 1 and `Data_in` = 3 → `A_count` = 3 and `C_out` = 0.
  - `Sync_clr` = 1 with `Load` = 1 → `A_count` = 0.
- **Cascade:** two instances, first stage's `C_out` driving second stage's `Count`, counting up from 00 for 25 cycles → second = 2, first = 5.
- **Saturation (`BINARY_COUNTER_SAT_EN` defined):** up from 8 for 3 cycles → 9, 9, 9 with `C_out` = 1 at 9. Down from 1 for 3 cycles → 0, 0, 0.
